// File: rtl/rsr_seq_ctrl.sv
// rsr_seq_ctrl: load/shift/count sequencer for a WIDTH-bit right-shift register.
// A parallel word is taken over a valid/ready handshake and shifted out LSB
// first on sout, one bit per cycle with hold low, followed by a one-cycle done.
// Optional feature macro: RSR_SEQ_CTRL_PARITY_EN appends one even-parity bit
// (PAR state) after the data bits.
//
// Handshake: a word is transferred in any cycle where in_valid && in_ready;
// in_ready is high only in IDLE and never while rst is high, and in_valid
// outside IDLE is dropped (no queueing). sout_valid qualifies sout each cycle.
module rsr_seq_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   input  logic             hold,
   output logic             sout,
   output logic             sout_valid,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef RSR_SEQ_CTRL_PARITY_EN
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2,
      PAR   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
`endif

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
`ifdef RSR_SEQ_CTRL_PARITY_EN
   logic             par;
`endif

   // Sequencer: capture on handshake, shift while not held, count down to the last bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef RSR_SEQ_CTRL_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg <= in_data;
                  cnt   <= CW'(WIDTH - 1);
`ifdef RSR_SEQ_CTRL_PARITY_EN
                  par   <= ^in_data;
`endif
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (!hold) begin
                  shreg <= {1'b0, shreg[WIDTH-1:1]};
                  // cnt stops at zero: the exit is taken on the last bit instead of wrapping
                  if (cnt == '0) begin
`ifdef RSR_SEQ_CTRL_PARITY_EN
                     state <= PAR;
`else
                     state <= DONE;
`endif
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
`ifdef RSR_SEQ_CTRL_PARITY_EN
            PAR: begin
               if (!hold) state <= DONE;
            end
`endif
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   assign in_ready = (state == IDLE) && !rst;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

`ifdef RSR_SEQ_CTRL_PARITY_EN
   assign sout       = (state == PAR) ? par : shreg[0];
   assign sout_valid = ((state == SHIFT) || (state == PAR)) && !hold;
`else
   assign sout       = shreg[0];
   assign sout_valid = (state == SHIFT) && !hold;
`endif

endmodule

// File: tb/tb_rsr_seq_ctrl.sv
// Directed bench for rsr_seq_ctrl: WIDTH=4 instance for the main sequences and
// a WIDTH=8 instance for the wide-word case. Honours RSR_SEQ_CTRL_PARITY_EN.
module tb_rsr_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       hold;
   logic       sout;
   logic       sout_valid;
   logic       busy;
   logic       done;

   logic       in_valid8;
   logic [7:0] in_data8;
   logic       in_ready8;
   logic       hold8;
   logic       sout8;
   logic       sout_valid8;
   logic       busy8;
   logic       done8;

   int n_cmp = 0;
   int n_err = 0;

   // clock / reset block
   always #5 clk = ~clk;

   rsr_seq_ctrl #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .hold       (hold),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done)
   );

   rsr_seq_ctrl #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid8),
      .in_data    (in_data8),
      .in_ready   (in_ready8),
      .hold       (hold8),
      .sout       (sout8),
      .sout_valid (sout_valid8),
      .busy       (busy8),
      .done       (done8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Handshake in the current cycle, then check every serial bit, parity, done and return to IDLE.
   task automatic xfer4(input logic [3:0] d, input logic [3:0] seq, input logic p);
      in_valid = 1'b1;
      in_data  = d;
      #1;
      chk("hs_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_data  = 4'($urandom_range(0, 15));
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("bit", sout, seq[i]);
         chk("bit_valid", sout_valid, 1);
         chk("bit_busy", busy, 1);
         chk("bit_nodone", done, 0);
         tick();
         #1;
      end
`ifdef RSR_SEQ_CTRL_PARITY_EN
      chk("par_bit", sout, p);
      chk("par_valid", sout_valid, 1);
      tick();
      #1;
`else
      p = p;
`endif
      chk("done_pulse", done, 1);
      chk("done_nvalid", sout_valid, 0);
      chk("done_ready", in_ready, 0);
      tick();
      #1;
      chk("idle_done", done, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      logic [3:0] seq;
      logic [7:0] seq8;

      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'hF;
      hold      = 1'b0;
      in_valid8 = 1'b0;
      in_data8  = 8'h00;
      hold8     = 1'b0;

      // reset state, in_valid high during reset must not transfer
      tick();
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sout", sout, 0);
      chk("rst_valid", sout_valid, 0);
      chk("rst_done", done, 0);
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rel_ready", in_ready, 1);
      chk("rel_busy", busy, 0);
      chk("rel_sout", sout, 0);
      chk("rel_ready8", in_ready8, 1);

      // basic words
      xfer4(4'b1011, 4'b1011, 1'b1);
      xfer4(4'b0110, 4'b0110, 1'b0);

      // hold for two cycles starting at N+2
      in_valid = 1'b1;
      in_data  = 4'b1001;
      #1;
      chk("h_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("h_b0", sout, 1);
      chk("h_b0v", sout_valid, 1);
      tick();
      hold = 1'b1;
      #1;
      chk("h_hold1", sout, 0);
      chk("h_hold1v", sout_valid, 0);
      chk("h_hold1busy", busy, 1);
      tick();
      #1;
      chk("h_hold2", sout, 0);
      chk("h_hold2v", sout_valid, 0);
      tick();
      hold = 1'b0;
      #1;
      chk("h_b1", sout, 0);
      chk("h_b1v", sout_valid, 1);
      tick();
      #1;
      chk("h_b2", sout, 0);
      tick();
      #1;
      chk("h_b3", sout, 1);
      chk("h_b3nd", done, 0);
      tick();
      #1;
`ifdef RSR_SEQ_CTRL_PARITY_EN
      chk("h_par", sout, 0);
      chk("h_parv", sout_valid, 1);
      tick();
      #1;
`endif
      chk("h_done", done, 1);
      tick();
      #1;
      chk("h_idle", in_ready, 1);

      // in_valid held with 4'hF during a transfer of 4'h5
      in_valid = 1'b1;
      in_data  = 4'h5;
      #1;
      chk("o_ready", in_ready, 1);
      tick();
      in_data = 4'hF;
      #1;
      seq = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         chk("o_bit", sout, seq[i]);
         chk("o_nready", in_ready, 0);
         tick();
         #1;
      end
`ifdef RSR_SEQ_CTRL_PARITY_EN
      chk("o_par", sout, 0);
      tick();
      #1;
`endif
      chk("o_done", done, 1);
      chk("o_done_nready", in_ready, 0);
      tick();
      #1;
      chk("o_f_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("o_f_bit", sout, 1);
         chk("o_f_valid", sout_valid, 1);
         tick();
         #1;
      end
`ifdef RSR_SEQ_CTRL_PARITY_EN
      chk("o_f_par", sout, 0);
      tick();
      #1;
`endif
      chk("o_f_done", done, 1);
      tick();
      #1;
      chk("o_f_idle", busy, 0);

      // reset asserted in N+2 of a transfer
      in_valid = 1'b1;
      in_data  = 4'b1011;
      #1;
      chk("r_ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("r_b0", sout, 1);
      tick();
      rst = 1'b1;
      #1;
      chk("r_ready_rst", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("r_busy", busy, 0);
      chk("r_valid", sout_valid, 0);
      chk("r_done", done, 0);
      chk("r_sout", sout, 0);
      chk("r_ready_after", in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         #1;
         chk("r_nodone", done, 0);
      end
      xfer4(4'b0001, 4'b0001, 1'b1);

      // WIDTH=8 word
      in_valid8 = 1'b1;
      in_data8  = 8'hA5;
      #1;
      chk("w8_ready", in_ready8, 1);
      tick();
      in_valid8 = 1'b0;
      #1;
      seq8 = 8'b10100101;
      for (int i = 0; i < 8; i++) begin
         chk("w8_bit", sout8, seq8[i]);
         chk("w8_valid", sout_valid8, 1);
         chk("w8_nodone", done8, 0);
         tick();
         #1;
      end
`ifdef RSR_SEQ_CTRL_PARITY_EN
      chk("w8_par", sout8, 0);
      tick();
      #1;
`endif
      chk("w8_done", done8, 1);
      chk("w8_busy", busy8, 1);
      tick();
      #1;
      chk("w8_idle", in_ready8, 1);
      chk("w8_idle_done", done8, 0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
